// File: rtl/aoi4_bist_pkg.sv
// Shared types, constants and the AOI4 golden model for the BIST controller.
// The golden function is also the bench's reference model.
package aoi4_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } bist_state_e;

    localparam int unsigned NUM_VEC = 16;
    localparam logic [4:0]  ERR_MAX = 5'd16;

    // vec = {a,b,c,d}; result = {e,f,g}
    function automatic logic [2:0] aoi4_golden_f(input logic [3:0] v);
        logic e;
        logic f;
        e = v[3] & v[2];
        f = v[1] & v[0];
        return {e, f, ~(e | f)};
    endfunction

endpackage

// File: rtl/aoi4_bist_ctrl_if.sv
// Stimulus/response bus between the BIST controller and the AOI gate.
// master drives a..d and samples e..g; slave is the gate side.
interface aoi4_bist_ctrl_if;

    logic dut_a;
    logic dut_b;
    logic dut_c;
    logic dut_d;
    logic dut_e;
    logic dut_f;
    logic dut_g;

    modport master (
        output dut_a, dut_b, dut_c, dut_d,
        input  dut_e, dut_f, dut_g
    );

    modport slave (
        input  dut_a, dut_b, dut_c, dut_d,
        output dut_e, dut_f, dut_g
    );

endinterface

// File: rtl/aoi4_golden.sv
// Combinational wrapper around the package golden model.
// Maps vec = {a,b,c,d} to the expected {e,f,g}.
import aoi4_bist_pkg::*;

module aoi4_golden (
    input  logic [3:0] vec,
    output logic [2:0] efg
);

    assign efg = aoi4_golden_f(vec);

endmodule

// File: rtl/aoi4_bist_ctrl.sv
// Exhaustive 16-vector BIST sweep for a 4-input AOI gate.
// Optional macro AOI4_BIST_STOP_ON_FAIL_EN: end the sweep at the first mismatch.
import aoi4_bist_pkg::*;

module aoi4_bist_ctrl #(
    parameter int unsigned HOLD = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    aoi4_bist_ctrl_if.master gate,
    output logic [3:0]       vec,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [4:0]       err_cnt,
    output logic [3:0]       first_fail
);

    localparam logic [1:0] IDLE  = ST_IDLE;
    localparam logic [1:0] DRIVE = ST_DRIVE;
    localparam logic [1:0] CHECK = ST_CHECK;
    localparam logic [1:0] DONE  = ST_DONE;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD - 1);
    localparam logic [3:0] VEC_LAST  = 4'(NUM_VEC - 1);

    logic [1:0] state;
    logic [7:0] hold_cnt;
    logic [2:0] gold;
    logic [2:0] resp;
    logic [3:0] drv;
    logic       mismatch;
    logic       last_vec;
    logic       hold_end;

    aoi4_golden u_golden (
        .vec (vec),
        .efg (gold)
    );

    assign resp     = {gate.dut_e, gate.dut_f, gate.dut_g};
    assign mismatch = (resp != gold);
    assign last_vec = (vec == VEC_LAST);
    assign hold_end = (hold_cnt == HOLD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            vec        <= 4'd0;
            hold_cnt   <= 8'd0;
            err_cnt    <= 5'd0;
            first_fail <= 4'd0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= DRIVE;
                        vec        <= 4'd0;
                        hold_cnt   <= 8'd0;
                        err_cnt    <= 5'd0;
                        first_fail <= 4'd0;
                    end
                end
                DRIVE: begin
                    if (hold_end) begin
                        state <= CHECK;
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                CHECK: begin
                    if (mismatch) begin
                        if (err_cnt < ERR_MAX) begin
                            err_cnt <= err_cnt + 5'd1;
                        end
                        if (err_cnt == 5'd0) begin
                            first_fail <= vec;
                        end
                    end
`ifdef AOI4_BIST_STOP_ON_FAIL_EN
                    if (mismatch || last_vec) begin
                        state <= DONE;
                    end else begin
                        state    <= DRIVE;
                        vec      <= vec + 4'd1;
                        hold_cnt <= 8'd0;
                    end
`else
                    if (last_vec) begin
                        state <= DONE;
                    end else begin
                        state    <= DRIVE;
                        vec      <= vec + 4'd1;
                        hold_cnt <= 8'd0;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    // DONE keeps presenting the last vector driven
    assign drv  = (state == IDLE) ? 4'd0 : vec;
    assign busy = (state == DRIVE) || (state == CHECK);
    assign done = (state == DONE);
    assign pass = done && (err_cnt == 5'd0);

    assign gate.dut_a = drv[3];
    assign gate.dut_b = drv[2];
    assign gate.dut_c = drv[1];
    assign gate.dut_d = drv[0];

endmodule
